// File: rtl/count_stats_capture.sv
// Batch latency statistics: collects count_global samples on each clk_stop strobe
// and offers last/min/max/sum per BATCH samples over a valid/ready handshake.
module count_stats_capture #(
  parameter int CNT_W = 5,
  parameter int BATCH = 8,
  parameter int SUM_W = 8
) (
  input  logic             clk,
  input  logic             GlobalReset_n,
  input  logic [CNT_W-1:0] count_global,
  input  logic             clk_stop,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_last,
  output logic [CNT_W-1:0] res_min,
  output logic [CNT_W-1:0] res_max,
  output logic [SUM_W-1:0] res_sum,
  output logic             overrun,
  output logic             wrap_seen
);

  localparam int N_W = $clog2(BATCH + 1);
  localparam logic [N_W-1:0]   LAST_N   = N_W'(BATCH - 1);
  localparam logic [CNT_W-1:0] ALL_ONES = {CNT_W{1'b1}};

  typedef enum logic {ACCUM, REPORT} state_t;

  state_t           state;
  logic [N_W-1:0]   n;
  logic [CNT_W-1:0] acc_min;
  logic [CNT_W-1:0] acc_max;
  logic [CNT_W-1:0] acc_last;
  logic [SUM_W-1:0] acc_sum;

  logic [CNT_W-1:0] upd_min;
  logic [CNT_W-1:0] upd_max;
  logic [SUM_W-1:0] upd_sum;
  logic             accept;

  function automatic logic [CNT_W-1:0] umin(input logic [CNT_W-1:0] a,
                                            input logic [CNT_W-1:0] b);
    return (b < a) ? b : a;
  endfunction

  function automatic logic [CNT_W-1:0] umax(input logic [CNT_W-1:0] a,
                                            input logic [CNT_W-1:0] b);
    return (b > a) ? b : a;
  endfunction

  always_comb begin
    upd_min = umin(acc_min, count_global);
    upd_max = umax(acc_max, count_global);
    upd_sum = acc_sum + SUM_W'(count_global);
    accept  = res_valid & res_ready;
  end

  always_ff @(posedge clk or negedge GlobalReset_n) begin
    if (!GlobalReset_n) begin
      state     <= ACCUM;
      n         <= '0;
      acc_min   <= ALL_ONES;
      acc_max   <= '0;
      acc_last  <= '0;
      acc_sum   <= '0;
      res_valid <= 1'b0;
      res_last  <= '0;
      res_min   <= '0;
      res_max   <= '0;
      res_sum   <= '0;
      overrun   <= 1'b0;
      wrap_seen <= 1'b0;
    end else begin
      // Wrap detection applies to every strobe, including ones dropped below.
      if (clk_stop && count_global == ALL_ONES)
        wrap_seen <= 1'b1;
      case (state)
        ACCUM: begin
          if (clk_stop) begin
            acc_min  <= upd_min;
            acc_max  <= upd_max;
            acc_sum  <= upd_sum;
            acc_last <= count_global;
            n        <= n + N_W'(1);
            if (n == LAST_N) begin
              res_min   <= upd_min;
              res_max   <= upd_max;
              res_sum   <= upd_sum;
              res_last  <= count_global;
              res_valid <= 1'b1;
              state     <= REPORT;
            end
          end
        end
        REPORT: begin
          if (accept) begin
            res_valid <= 1'b0;
            state     <= ACCUM;
            // A strobe coinciding with accept seeds the next batch.
            if (clk_stop) begin
              acc_min  <= count_global;
              acc_max  <= count_global;
              acc_last <= count_global;
              acc_sum  <= SUM_W'(count_global);
              n        <= N_W'(1);
            end else begin
              acc_min  <= ALL_ONES;
              acc_max  <= '0;
              acc_last <= '0;
              acc_sum  <= '0;
              n        <= '0;
            end
          end else if (clk_stop) begin
            overrun <= 1'b1;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_count_stats_capture.sv
// Directed bench for count_stats_capture: batch statistics, back-pressure,
// accept/strobe overlap, wrap detection and asynchronous reset.
module tb_count_stats_capture;

  logic       clk;
  logic       GlobalReset_n;
  logic [4:0] count_global;
  logic       clk_stop;
  logic       res_valid;
  logic       res_ready;
  logic [4:0] res_last;
  logic [4:0] res_min;
  logic [4:0] res_max;
  logic [7:0] res_sum;
  logic       overrun;
  logic       wrap_seen;

  int checks   = 0;
  int failures = 0;

  count_stats_capture #(.CNT_W(5), .BATCH(8), .SUM_W(8)) dut (
    .clk           (clk),
    .GlobalReset_n (GlobalReset_n),
    .count_global  (count_global),
    .clk_stop      (clk_stop),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_last      (res_last),
    .res_min       (res_min),
    .res_max       (res_max),
    .res_sum       (res_sum),
    .overrun       (overrun),
    .wrap_seen     (wrap_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One-cycle strobe; returns at the falling edge after the sampling edge.
  task automatic strobe(input logic [4:0] s);
    @(negedge clk);
    count_global = s;
    clk_stop     = 1'b1;
    @(negedge clk);
    clk_stop     = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic [4:0] l, input logic [4:0] mn,
                         input logic [4:0] mx, input logic [7:0] sm);
    chk({tag, "_valid"}, res_valid, 1);
    chk({tag, "_last"},  res_last,  l);
    chk({tag, "_min"},   res_min,   mn);
    chk({tag, "_max"},   res_max,   mx);
    chk({tag, "_sum"},   res_sum,   sm);
  endtask

  initial begin
    GlobalReset_n = 1'b0;
    count_global  = '0;
    clk_stop      = 1'b0;
    res_ready     = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid",   res_valid,   0);
    chk("rst_sum",     res_sum,     0);
    chk("rst_min",     res_min,     0);
    chk("rst_overrun", overrun,     0);
    chk("rst_wrap",    wrap_seen,   0);
    chk("rst_accmin",  dut.acc_min, 5'h1f);
    GlobalReset_n = 1'b1;

    // Basic batch with consumer always ready
    res_ready = 1'b1;
    strobe(3); strobe(7); strobe(1); strobe(9);
    strobe(4); strobe(4); strobe(2);
    chk("b1_pre_valid", res_valid, 0);
    strobe(10);
    chk_res("b1", 10, 1, 10, 40);
    @(negedge clk);
    chk("b1_acc_valid", res_valid, 0);
    chk("b1_acc_n",     dut.n,     0);
    res_ready = 1'b0;

    // Accept and strobe in the same cycle
    for (int i = 0; i < 8; i++) strobe(1);
    chk_res("b2", 1, 1, 1, 8);
    @(negedge clk);
    count_global = 5'd6;
    clk_stop     = 1'b1;
    res_ready    = 1'b1;
    @(negedge clk);
    clk_stop  = 1'b0;
    res_ready = 1'b0;
    chk("ov_valid",   res_valid,   0);
    chk("ov_overrun", overrun,     0);
    chk("ov_n",       dut.n,       1);
    chk("ov_sum",     dut.acc_sum, 6);
    for (int i = 0; i < 6; i++) strobe(0);
    chk("b3_pre_valid", res_valid, 0);
    strobe(0);
    chk_res("b3", 0, 0, 6, 6);

    // Back-pressure: strobes while result pending are dropped
    strobe(20);
    strobe(0);
    chk_res("bp", 0, 0, 6, 6);
    chk("bp_overrun", overrun, 1);
    @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("bp_acc_valid", res_valid, 0);
    chk("bp_acc_n",     dut.n,     0);
    chk("bp_overrun2",  overrun,   1);
    chk("wrap_pre",     wrap_seen, 0);

    // All-ones samples: wrap flag and largest sum
    strobe(31);
    chk("wrap_set", wrap_seen, 1);
    for (int i = 0; i < 7; i++) strobe(31);
    chk_res("b4", 31, 31, 31, 248);
    chk("wrap_sticky", wrap_seen, 1);

    // Asynchronous reset while a result is pending
    #2 GlobalReset_n = 1'b0;
    #1;
    chk("r2_valid",   res_valid,   0);
    chk("r2_sum",     res_sum,     0);
    chk("r2_max",     res_max,     0);
    chk("r2_overrun", overrun,     0);
    chk("r2_wrap",    wrap_seen,   0);
    chk("r2_accmin",  dut.acc_min, 5'h1f);
    chk("r2_n",       dut.n,       0);
    @(negedge clk);
    GlobalReset_n = 1'b1;

    // clk_stop held high: one sample per cycle
    res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("hold_pre_valid", res_valid, 0);
      count_global = 5'(i);
      clk_stop     = 1'b1;
    end
    @(negedge clk);
    clk_stop = 1'b0;
    chk_res("b5", 7, 0, 7, 28);
    @(negedge clk);
    chk("b5_acc_valid", res_valid, 0);
    chk("b5_overrun",   overrun,   0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
